// File: rtl/store_commit_buffer_if.sv
// Store commit buffer bus bundle: ROB store-commit port, D-cache write
// port, load-forwarding lookup and occupancy status.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface store_commit_buffer_if #(
   parameter int ADDR_WIDTH     = 32,
   parameter int SCB_DEPTH_BITS = 2
);
   logic                      st_wr_en;
   logic [ADDR_WIDTH-1:0]     st_wr_addr;
   logic [31:0]               st_wr_data;
   logic                      st_stall;

   logic                      mem_req_valid;
   logic [ADDR_WIDTH-1:0]     mem_req_addr;
   logic [31:0]               mem_req_data;
   logic                      mem_req_ready;
   logic                      mem_ack;

   logic                      ld_check_valid;
   logic [ADDR_WIDTH-1:0]     ld_check_addr;
   logic                      ld_fwd_hit;
   logic [31:0]               ld_fwd_data;

   logic                      empty;
   logic [SCB_DEPTH_BITS:0]   count;

   modport slave (
      input  st_wr_en, st_wr_addr, st_wr_data,
      output st_stall,
      output mem_req_valid, mem_req_addr, mem_req_data,
      input  mem_req_ready, mem_ack,
      input  ld_check_valid, ld_check_addr,
      output ld_fwd_hit, ld_fwd_data,
      output empty, count
   );

   modport master (
      output st_wr_en, st_wr_addr, st_wr_data,
      input  st_stall,
      input  mem_req_valid, mem_req_addr, mem_req_data,
      output mem_req_ready, mem_ack,
      output ld_check_valid, ld_check_addr,
      input  ld_fwd_hit, ld_fwd_data,
      input  empty, count
   );
endinterface

// File: rtl/store_commit_buffer.sv
// Store commit buffer: queues committed stores from the ROB, drains them in
// order to the D-cache with a req/ack handshake, and forwards data from the
// youngest matching buffered store to younger loads. Never flushed.
module store_commit_buffer #(
   parameter int SCB_DEPTH      = 4,
   parameter int SCB_DEPTH_BITS = 2,
   parameter int ADDR_WIDTH     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   store_commit_buffer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } drain_state_t;

   drain_state_t                state;

   logic [ADDR_WIDTH-1:0]       entry_addr [SCB_DEPTH];
   logic [31:0]                 entry_data [SCB_DEPTH];
   logic [SCB_DEPTH-1:0]        entry_valid;

   logic [SCB_DEPTH_BITS:0]     wr_ptr;
   logic [SCB_DEPTH_BITS:0]     rd_ptr;
   logic [SCB_DEPTH_BITS-1:0]   wr_idx;
   logic [SCB_DEPTH_BITS-1:0]   rd_idx;
   logic [SCB_DEPTH_BITS-1:0]   next_rd_idx;
   logic [SCB_DEPTH_BITS:0]     occupancy;
   logic [SCB_DEPTH_BITS:0]     occupancy_after;
   logic                        full;
   logic                        is_empty;
   logic                        enq;
   logic                        pop;
   logic                        next_head_bypass;
   logic [ADDR_WIDTH-1:0]       next_head_addr;
   logic [31:0]                 next_head_data;

   logic                        fwd_hit_c;
   logic [31:0]                 fwd_data_c;
   logic [SCB_DEPTH_BITS-1:0]   fwd_idx;

   // Byte offset of a load never takes part in word matching.
   logic                        ld_offset_unused;
   assign ld_offset_unused = &{1'b0, bus.ld_check_addr[1:0]};

   assign wr_idx      = wr_ptr[SCB_DEPTH_BITS-1:0];
   assign rd_idx      = rd_ptr[SCB_DEPTH_BITS-1:0];
   assign next_rd_idx = rd_idx + SCB_DEPTH_BITS'(1);

   assign is_empty  = (wr_ptr == rd_ptr);
   assign full      = (wr_idx == rd_idx) &&
                      (wr_ptr[SCB_DEPTH_BITS] != rd_ptr[SCB_DEPTH_BITS]);
   assign occupancy = wr_ptr - rd_ptr;

   assign enq = bus.st_wr_en && !full;
   assign pop = (state == WAIT) && bus.mem_ack;

   assign occupancy_after = occupancy - (SCB_DEPTH_BITS+1)'(pop)
                                      + (SCB_DEPTH_BITS+1)'(enq);

   // When the buffer held one store and a new one lands on the ack edge, the
   // new head is still on the input bus rather than in the array.
   assign next_head_bypass = enq && (wr_idx == next_rd_idx);
   assign next_head_addr   = next_head_bypass ? bus.st_wr_addr : entry_addr[next_rd_idx];
   assign next_head_data   = next_head_bypass ? bus.st_wr_data : entry_data[next_rd_idx];

   assign bus.st_stall = full;
   assign bus.empty    = is_empty;
   assign bus.count    = occupancy;

   // Entry storage and pointers: push at wr_ptr on enqueue, retire at rd_ptr on ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         entry_valid <= '0;
      end else begin
         if (enq) begin
            entry_addr[wr_idx]  <= bus.st_wr_addr;
            entry_data[wr_idx]  <= bus.st_wr_data;
            entry_valid[wr_idx] <= 1'b1;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            entry_valid[rd_idx] <= 1'b0;
            rd_ptr              <= rd_ptr + 1'b1;
         end
      end
   end

   // Drain FSM: present the head store, hand it off on ready, retire it on ack.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         bus.mem_req_valid <= 1'b0;
         bus.mem_req_addr  <= '0;
         bus.mem_req_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!is_empty) begin
                  state             <= REQ;
                  bus.mem_req_valid <= 1'b1;
                  bus.mem_req_addr  <= entry_addr[rd_idx];
                  bus.mem_req_data  <= entry_data[rd_idx];
               end
            end
            REQ: begin
               if (bus.mem_req_ready) begin
                  state             <= WAIT;
                  bus.mem_req_valid <= 1'b0;
               end
            end
            WAIT: begin
               if (bus.mem_ack) begin
                  if (occupancy_after != '0) begin
                     state             <= REQ;
                     bus.mem_req_valid <= 1'b1;
                     bus.mem_req_addr  <= next_head_addr;
                     bus.mem_req_data  <= next_head_data;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state             <= IDLE;
               bus.mem_req_valid <= 1'b0;
            end
         endcase
      end
   end

   // Load forwarding: scan oldest to youngest so the youngest word match wins.
   always_comb begin
      fwd_hit_c  = 1'b0;
      fwd_data_c = '0;
      fwd_idx    = rd_idx;
      for (int i = 0; i < SCB_DEPTH; i++) begin
         fwd_idx = rd_idx + SCB_DEPTH_BITS'(i);
         if (bus.ld_check_valid && entry_valid[fwd_idx] &&
             (entry_addr[fwd_idx][ADDR_WIDTH-1:2] == bus.ld_check_addr[ADDR_WIDTH-1:2])) begin
            fwd_hit_c  = 1'b1;
            fwd_data_c = entry_data[fwd_idx];
         end
      end
   end

   assign bus.ld_fwd_hit  = fwd_hit_c;
   assign bus.ld_fwd_data = fwd_data_c;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Testbench for store_commit_buffer: directed scenarios plus a randomized
// phase, all checked against a queue-based model of the buffered stores and
// a small D-cache responder.
module tb_store_commit_buffer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } store_t;

   logic clk;
   logic rst_n;

   store_commit_buffer_if #(.ADDR_WIDTH(32), .SCB_DEPTH_BITS(2)) sif ();

   store_commit_buffer #(
      .SCB_DEPTH      (DEPTH),
      .SCB_DEPTH_BITS (2),
      .ADDR_WIDTH     (32)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   store_t      q[$];
   bit          outstanding;
   int          ack_cnt;
   int          ack_lat_cfg;
   logic        ready_cfg;

   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_data;
   logic [2:0]  s_count;
   logic        s_empty;
   logic        s_stall;
   logic        s_hit;
   logic [31:0] s_fwd;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check against the model, then advance the model at posedge.
   task automatic applyStimulus(input logic wr, input logic [31:0] wa, input logic [31:0] wd,
                                input logic ldv, input logic [31:0] la, input logic stray,
                                output bit accepted);
      logic        exp_hit;
      logic [31:0] exp_fwd;
      logic        hs;
      bit          full_b;
      @(negedge clk);
      sif.st_wr_en       = wr;
      sif.st_wr_addr     = wa;
      sif.st_wr_data     = wd;
      sif.ld_check_valid = ldv;
      sif.ld_check_addr  = la;
      sif.mem_req_ready  = ready_cfg;
      sif.mem_ack        = stray && !outstanding;
      if (outstanding) begin
         if (ack_cnt <= 1) sif.mem_ack = 1'b1;
         else ack_cnt--;
      end
      #1;
      s_valid = sif.mem_req_valid;
      s_addr  = sif.mem_req_addr;
      s_data  = sif.mem_req_data;
      s_count = sif.count;
      s_empty = sif.empty;
      s_stall = sif.st_stall;
      s_hit   = sif.ld_fwd_hit;
      s_fwd   = sif.ld_fwd_data;

      exp_hit = 1'b0;
      exp_fwd = '0;
      if (ldv) begin
         for (int i = 0; i < q.size(); i++) begin
            if (q[i].addr[31:2] == la[31:2]) begin
               exp_hit = 1'b1;
               exp_fwd = q[i].data;
            end
         end
      end
      checkOutput("count", 32'(s_count), 32'(q.size()));
      checkOutput("empty", 32'(s_empty), 32'(q.size() == 0));
      checkOutput("stall", 32'(s_stall), 32'(q.size() == DEPTH));
      checkOutput("fwd_hit", 32'(s_hit), 32'(exp_hit));
      checkOutput("fwd_data", s_fwd, exp_fwd);
      if (outstanding)
         checkOutput("wait_noreq", 32'(s_valid), 32'd0);
      else if (q.size() == 0)
         checkOutput("idle_noreq", 32'(s_valid), 32'd0);
      if (s_valid && q.size() > 0) begin
         checkOutput("req_addr", s_addr, q[0].addr);
         checkOutput("req_data", s_data, q[0].data);
      end
      hs = s_valid && ready_cfg;

      @(posedge clk);
      full_b   = (q.size() == DEPTH);
      accepted = 1'b0;
      if (sif.mem_ack && outstanding) begin
         void'(q.pop_front());
         outstanding = 1'b0;
      end
      if (hs) begin
         outstanding = 1'b1;
         ack_cnt     = ack_lat_cfg;
      end
      if (wr && !full_b) begin
         q.push_back('{addr: wa, data: wd});
         accepted = 1'b1;
      end
   endtask

   task automatic idleCycle();
      bit acc;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, acc);
   endtask

   // Re-present a store until the buffer takes it, within a cycle budget.
   task automatic pushStore(input logic [31:0] a, input logic [31:0] d);
      bit acc;
      acc = 1'b0;
      for (int k = 0; k < 40 && !acc; k++)
         applyStimulus(1'b1, a, d, 1'b0, 32'h0, 1'b0, acc);
      checkOutput("push_accepted", 32'(acc), 32'd1);
   endtask

   task automatic drainAll();
      ready_cfg = 1'b1;
      for (int k = 0; k < 300 && (q.size() != 0 || outstanding); k++)
         idleCycle();
      checkOutput("drain_done", 32'(q.size() == 0 && !outstanding), 32'd1);
   endtask

   task automatic doReset(input logic [31:0] la);
      @(negedge clk);
      rst_n              = 1'b0;
      sif.st_wr_en       = 1'b0;
      sif.mem_ack        = 1'b0;
      sif.mem_req_ready  = 1'b0;
      sif.ld_check_valid = 1'b1;
      sif.ld_check_addr  = la;
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("rst_stall", 32'(sif.st_stall), 32'd0);
      checkOutput("rst_valid", 32'(sif.mem_req_valid), 32'd0);
      checkOutput("rst_hit", 32'(sif.ld_fwd_hit), 32'd0);
      checkOutput("rst_fwd", sif.ld_fwd_data, 32'd0);
      checkOutput("rst_empty", 32'(sif.empty), 32'd1);
      checkOutput("rst_count", 32'(sif.count), 32'd0);
      checkOutput("rst_addr", sif.mem_req_addr, 32'd0);
      checkOutput("rst_data", sif.mem_req_data, 32'd0);
      rst_n = 1'b1;
      q.delete();
      outstanding = 1'b0;
      ack_cnt     = 0;
   endtask

   // Directed scenarios followed by a randomized run.
   initial begin
      bit acc;
      checks = 0;
      errors = 0;
      outstanding = 1'b0;
      ack_cnt = 0;
      ack_lat_cfg = 1;
      ready_cfg = 1'b0;
      rst_n = 1'b0;
      sif.st_wr_en = 1'b0;
      sif.st_wr_addr = '0;
      sif.st_wr_data = '0;
      sif.mem_req_ready = 1'b0;
      sif.mem_ack = 1'b0;
      sif.ld_check_valid = 1'b0;
      sif.ld_check_addr = '0;

      doReset(32'h0);

      // Single store: request appears two cycles after the enqueue.
      ready_cfg = 1'b1;
      ack_lat_cfg = 1;
      applyStimulus(1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, acc);
      idleCycle();
      checkOutput("lat_cycle1", 32'(s_valid), 32'd0);
      idleCycle();
      checkOutput("lat_cycle2", 32'(s_valid), 32'd1);
      checkOutput("lat_addr", s_addr, 32'h100);
      checkOutput("lat_data", s_data, 32'hDEADBEEF);
      idleCycle();
      idleCycle();
      checkOutput("single_empty", 32'(s_empty), 32'd1);
      checkOutput("single_count", 32'(s_count), 32'd0);

      // Fill and stall: fifth store is refused until the first ack.
      ready_cfg = 1'b0;
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 32'h700 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b0, acc);
      checkOutput("fifth_refused", 32'(acc), 32'd0);
      idleCycle();
      checkOutput("fill_count", 32'(s_count), 32'd4);
      checkOutput("fill_stall", 32'(s_stall), 32'd1);
      ready_cfg = 1'b1;
      pushStore(32'h710, 32'hA4);
      drainAll();

      // Ordering across pointer wrap.
      ack_lat_cfg = 3;
      for (int i = 0; i < 10; i++)
         pushStore(32'h200 + 32'(4 * i), 32'(i));
      drainAll();

      // Youngest-match forwarding.
      ready_cfg = 1'b0;
      pushStore(32'h300, 32'h11);
      pushStore(32'h304, 32'h22);
      pushStore(32'h301, 32'h33);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h302, 1'b0, acc);
      checkOutput("fwd_young_hit", 32'(s_hit), 32'd1);
      checkOutput("fwd_young_data", s_fwd, 32'h33);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h308, 1'b0, acc);
      checkOutput("fwd_miss_hit", 32'(s_hit), 32'd0);
      checkOutput("fwd_miss_data", s_fwd, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h300, 1'b0, acc);
      checkOutput("fwd_novalid_hit", 32'(s_hit), 32'd0);
      ack_lat_cfg = 1;
      drainAll();

      // In-flight forwarding, then enqueue on the same edge as the ack.
      ready_cfg = 1'b1;
      ack_lat_cfg = 6;
      pushStore(32'h400, 32'hAA);
      for (int k = 0; k < 10 && !outstanding; k++) idleCycle();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h400, 1'b0, acc);
      checkOutput("inflight_hit", 32'(s_hit), 32'd1);
      checkOutput("inflight_data", s_fwd, 32'hAA);
      for (int k = 0; k < 10 && !(outstanding && ack_cnt == 1); k++) idleCycle();
      checkOutput("simul_setup", 32'(outstanding && ack_cnt == 1), 32'd1);
      applyStimulus(1'b1, 32'h500, 32'hBB, 1'b0, 32'h0, 1'b0, acc);
      checkOutput("simul_count_pre", 32'(s_count), 32'd1);
      idleCycle();
      checkOutput("simul_count_post", 32'(s_count), 32'd1);
      checkOutput("simul_valid", 32'(s_valid), 32'd1);
      checkOutput("simul_addr", s_addr, 32'h500);
      checkOutput("simul_data", s_data, 32'hBB);
      ack_lat_cfg = 2;
      drainAll();

      // Reset while waiting on the cache with three entries buffered.
      ready_cfg = 1'b1;
      ack_lat_cfg = 50;
      pushStore(32'h800, 32'h1);
      pushStore(32'h804, 32'h2);
      pushStore(32'h808, 32'h3);
      for (int k = 0; k < 10 && !outstanding; k++) idleCycle();
      idleCycle();
      checkOutput("midrst_count", 32'(s_count), 32'd3);
      checkOutput("midrst_inwait", 32'(outstanding), 32'd1);
      doReset(32'h800);
      for (int k = 0; k < 4; k++)
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h800, 1'b1, acc);
      checkOutput("stray_count", 32'(s_count), 32'd0);
      checkOutput("stray_valid", 32'(s_valid), 32'd0);

      // Randomized traffic with narrow address range to exercise matching.
      for (int n = 0; n < 500; n++) begin
         logic [31:0] wa;
         logic [31:0] la;
         ready_cfg   = ($urandom_range(0, 3) != 0);
         ack_lat_cfg = int'($urandom_range(1, 4));
         wa = 32'h900 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         la = 32'h900 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
         applyStimulus(1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)), la,
                       ($urandom_range(0, 3) == 0), acc);
      end
      drainAll();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
